quad_clock_gen: RTL and testbench
=================================

QUAD_CLOCK_GEN -- requirements
Module: quad_clock_gen

Interface
REQ-001 SHALL have parameter DIV, default 4, giving master cycles per quarter-phase at SPEED=0; legal range 2..64.
REQ-002 SHALL have parameter WAIT_MAX, default 16, giving the maximum stretch quarters per bus cycle; 0 means unlimited; legal range 0..255.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, giving the nWAIT synchroniser depth; legal range 2..3.
REQ-004 Ports:
  MHZ48  in  1  master clock, single clock domain; all logic on its rising edge.
  RESET  in  1  synchronous reset, active-high.
  nWAIT  in  1  asynchronous stretch request, active-low.
  SPEED  in  2  quarter length select: DIV<<SPEED master cycles.
  CLR_TO in  1  clears WAIT_TO.
  nE     out 1  inverted CPU E clock.
  nQ     out 1  inverted CPU Q clock.
  MHZ12  out 1  free-running MHZ48/4.
  CYC_END out 1 one-cycle pulse on the edge where E falls.
  WAIT_ACTIVE out 1 high while the current cycle is being stretched.
  WAIT_TO out 1 sticky stretch-timeout flag.

Function
REQ-005 SHALL sequence four quarter phases P0(E0,Q0) -> P1(E0,Q1) -> P2(E1,Q1) -> P3(E1,Q0) -> P0; nE=~E, nQ=~Q, all registered, with no combinational output path.
REQ-006 SHALL advance the phase, and reset the quarter counter to 0, on the edge where counter == QLEN-1; otherwise counter increments; QLEN = DIV<<speed_l.
REQ-007 SHALL latch SPEED into speed_l only on the P3->P0 transition and during reset; SPEED changes mid-cycle take effect from the next P0.
REQ-008 SHALL synchronise nWAIT through SYNC_STAGES flops, all reset to 1; only the synchronised value (wsync) is used.
REQ-009 At end of P3 (counter == QLEN-1), if wsync=0 and (WAIT_MAX=0 or wait_cnt < WAIT_MAX): SHALL stay in P3, restart the counter, increment wait_cnt (saturating at 255), and set WAIT_ACTIVE=1.
REQ-010 At end of P3, otherwise: SHALL go to P0, pulse CYC_END for one master cycle, clear wait_cnt, and clear WAIT_ACTIVE.
REQ-011 SHALL set WAIT_TO when P3 ends with wsync=0 because wait_cnt == WAIT_MAX (WAIT_MAX != 0).
REQ-012 CLR_TO=1 SHALL clear WAIT_TO; when set and clear coincide, set wins.
REQ-013 nWAIT SHALL have no effect in P0, P1 or P2; Q stays low and E stays high for the whole stretch.
REQ-014 MHZ12 SHALL toggle every 2 master cycles, independent of phase, SPEED and wait.
REQ-015 Unstretched E period SHALL be 4*QLEN master cycles, with 50% E duty and Q leading E by QLEN.

Reset
REQ-016 While RESET=1 on an edge: phase=P0, counter=0, nE=1, nQ=1, MHZ12=0, CYC_END=0, WAIT_ACTIVE=0, WAIT_TO=0, wait_cnt=0, synchroniser=1s, speed_l=SPEED.
REQ-017 Reset asserted mid-stretch or mid-quarter SHALL abort the cycle immediately with no CYC_END pulse; the sequence restarts at P0 counter 0 on the first non-reset edge.
REQ-018 RESET SHALL take priority over CLR_TO, nWAIT and SPEED.

Verification (DIV=4, WAIT_MAX=16, SYNC_STAGES=2)
REQ-019 Release reset with SPEED=0 and nWAIT=1 -> nQ falls 4 cycles after release, nE falls at 8, nQ rises at 12, nE rises at 16; CYC_END pulses every 16 cycles; MHZ12 period is 4.
REQ-020 Switch SPEED 0->2 during P1 -> the current cycle completes at 16 cycles; the next E period is 64 cycles (QLEN=16).
REQ-021 Hold nWAIT low from P2 onward for 100 cycles -> E high for 2+16 quarters = 72 cycles; WAIT_ACTIVE high during the stretch; WAIT_TO=1 at exit; CYC_END pulses once.
REQ-022 Apply a single nWAIT low pulse whose synchronised value is low only at the end of the first P3 quarter -> exactly one extra quarter; E high for 12 cycles; WAIT_TO stays 0.
REQ-023 Assert CLR_TO on the same edge WAIT_TO sets -> WAIT_TO=1; assert CLR_TO alone next cycle -> WAIT_TO=0.
REQ-024 Assert RESET for 1 cycle mid-stretch -> next edge: nE=1, nQ=1, WAIT_ACTIVE=0, WAIT_TO=0, no CYC_END; the normal sequence then resumes per REQ-019.

Source files
------------

// File: rtl/quad_clock_gen.sv
// Four-phase E/Q clock generator with nWAIT cycle stretching, a bounded stretch timeout
// and a free-running divide-by-4 clock.
//
//   state | meaning
//   P0    | E low,  Q low  (cycle start)
//   P1    | E low,  Q high
//   P2    | E high, Q high
//   P3    | E high, Q low  (stretchable by nWAIT)
module quad_clock_gen #(
  parameter int DIV         = 4,
  parameter int WAIT_MAX    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       MHZ48,
  input  logic       RESET,
  input  logic       nWAIT,
  input  logic [1:0] SPEED,
  input  logic       CLR_TO,
  output logic       nE,
  output logic       nQ,
  output logic       MHZ12,
  output logic       CYC_END,
  output logic       WAIT_ACTIVE,
  output logic       WAIT_TO
);

  localparam int CW = $clog2(DIV * 8 + 1);

  typedef enum logic [1:0] {P0 = 2'b00, P1 = 2'b01, P2 = 2'b10, P3 = 2'b11} phase_t;

  phase_t                 phase_q, phase_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             speed_q, speed_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   div_q, mhz12_q;
  logic                   ne_q, ne_d, nq_q, nq_d;
  logic                   cyc_end_q, cyc_end_d;
  logic                   wait_act_q, wait_act_d;
  logic                   wait_to_q, wait_to_d;

  logic          wsync;
  logic [CW-1:0] qlen_m1;
  logic          quarter_end;
  logic          can_wait;
  logic          wait_to_set;

  assign wsync       = sync_q[SYNC_STAGES-1];
  assign qlen_m1     = (CW'(DIV) << speed_q) - CW'(1);
  assign quarter_end = (cnt_q == qlen_m1);
  assign can_wait    = (WAIT_MAX == 0) || (wait_cnt_q < 8'(WAIT_MAX));

  always_ff @(posedge MHZ48) begin
    if (RESET) begin
      phase_q    <= P0;
      cnt_q      <= '0;
      speed_q    <= SPEED;
      wait_cnt_q <= '0;
      sync_q     <= '1;
      div_q      <= 1'b0;
      mhz12_q    <= 1'b0;
      ne_q       <= 1'b1;
      nq_q       <= 1'b1;
      cyc_end_q  <= 1'b0;
      wait_act_q <= 1'b0;
      wait_to_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      speed_q    <= speed_d;
      wait_cnt_q <= wait_cnt_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], nWAIT};
      div_q      <= ~div_q;
      mhz12_q    <= mhz12_q ^ div_q;
      ne_q       <= ne_d;
      nq_q       <= nq_d;
      cyc_end_q  <= cyc_end_d;
      wait_act_q <= wait_act_d;
      wait_to_q  <= wait_to_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q + CW'(1);
    speed_d     = speed_q;
    wait_cnt_d  = wait_cnt_q;
    wait_act_d  = wait_act_q;
    cyc_end_d   = 1'b0;
    wait_to_set = 1'b0;
    if (quarter_end) begin
      cnt_d = '0;
      unique case (phase_q)
        P0: phase_d = P1;
        P1: phase_d = P2;
        P2: phase_d = P3;
        P3: begin
          if (!wsync && can_wait) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            wait_act_d = 1'b1;
          end else begin
            phase_d     = P0;
            speed_d     = SPEED;
            cyc_end_d   = 1'b1;
            wait_cnt_d  = '0;
            wait_act_d  = 1'b0;
            // Still waiting here means the stretch budget ran out.
            wait_to_set = !wsync && (WAIT_MAX != 0);
          end
        end
        default: phase_d = P0;
      endcase
    end
    wait_to_d = wait_to_set ? 1'b1 : (CLR_TO ? 1'b0 : wait_to_q);
  end

  // Outputs are decoded from the next phase so they land in flops with the phase.
  always_comb begin
    ne_d = ~phase_d[1];
    nq_d = ~(phase_d[1] ^ phase_d[0]);
  end

  assign nE          = ne_q;
  assign nQ          = nq_q;
  assign MHZ12       = mhz12_q;
  assign CYC_END     = cyc_end_q;
  assign WAIT_ACTIVE = wait_act_q;
  assign WAIT_TO     = wait_to_q;

endmodule

// File: tb/tb_quad_clock_gen.sv
// Bench for quad_clock_gen: stimulus queues one expected shape per bus cycle,
// a monitor measures each cycle between CYC_END pulses and compares.
module tb_quad_clock_gen;

  logic       clk = 1'b0;
  logic       RESET;
  logic       nWAIT;
  logic [1:0] SPEED;
  logic       CLR_TO;
  logic       nE, nQ, MHZ12, CYC_END, WAIT_ACTIVE, WAIT_TO;

  quad_clock_gen #(.DIV(4), .WAIT_MAX(16), .SYNC_STAGES(2)) dut (
    .MHZ48      (clk),
    .RESET      (RESET),
    .nWAIT      (nWAIT),
    .SPEED      (SPEED),
    .CLR_TO     (CLR_TO),
    .nE         (nE),
    .nQ         (nQ),
    .MHZ12      (MHZ12),
    .CYC_END    (CYC_END),
    .WAIT_ACTIVE(WAIT_ACTIVE),
    .WAIT_TO    (WAIT_TO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int e_hi;
    int q_hi;
    int q_first;
    int e_first;
    int wa_hi;
    int wto;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   t       = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_normal(input int l);
    exp_q.push_back('{4*l, 2*l, 2*l, l, 2*l, 0, 0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic wait_until(input int target);
    while (t < target) tick();
  endtask

  // Monitor: a cycle runs from the sample after a reset edge or a CYC_END pulse
  // up to (not including) the next CYC_END sample.
  logic rst_edge = 1'b1;
  int   m_len, m_ehi, m_qhi, m_qf, m_ef, m_wa;
  int   m_cyc = 0;

  always @(posedge clk) rst_edge <= RESET;

  always @(negedge clk) begin
    if (rst_edge && CYC_END) begin
      n_total++;
      $display("FAIL cyc_end_in_reset: got CYC_END=1, expected 0");
    end
    if (!rst_edge && CYC_END) begin
      m_cyc++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL cyc%0d_unexpected: got CYC_END with nothing queued, expected no pulse", m_cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("cyc%0d_len", m_cyc), m_len, e.len);
        check($sformatf("cyc%0d_e_high", m_cyc), m_ehi, e.e_hi);
        check($sformatf("cyc%0d_q_high", m_cyc), m_qhi, e.q_hi);
        check($sformatf("cyc%0d_q_rise", m_cyc), m_qf, e.q_first);
        check($sformatf("cyc%0d_e_rise", m_cyc), m_ef, e.e_first);
        check($sformatf("cyc%0d_wait_active", m_cyc), m_wa, e.wa_hi);
        check($sformatf("cyc%0d_wait_to", m_cyc), int'(WAIT_TO), e.wto);
      end
    end
    if (rst_edge || CYC_END) begin
      m_len = 1;
      m_ehi = nE ? 0 : 1;
      m_qhi = nQ ? 0 : 1;
      m_ef  = nE ? -1 : 0;
      m_qf  = nQ ? -1 : 0;
      m_wa  = WAIT_ACTIVE ? 1 : 0;
    end else begin
      if (!nE) begin
        m_ehi++;
        if (m_ef < 0) m_ef = m_len;
      end
      if (!nQ) begin
        m_qhi++;
        if (m_qf < 0) m_qf = m_len;
      end
      if (WAIT_ACTIVE) m_wa++;
      m_len++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mhz_pat;
    mhz_pat = 8'b0110_0110;
    RESET  = 1'b1;
    nWAIT  = 1'b1;
    SPEED  = 2'd0;
    CLR_TO = 1'b0;
    repeat (3) tick();

    check("rst_nE", int'(nE), 1);
    check("rst_nQ", int'(nQ), 1);
    check("rst_mhz12", int'(MHZ12), 0);
    check("rst_cyc_end", int'(CYC_END), 0);
    check("rst_wait_active", int'(WAIT_ACTIVE), 0);
    check("rst_wait_to", int'(WAIT_TO), 0);

    push_normal(4);                              // cycles 1-3 at QLEN=4
    push_normal(4);
    push_normal(4);
    push_normal(16);                             // SPEED=2 from cycle 4
    push_normal(4);                              // back to SPEED=0
    exp_q.push_back('{80, 72, 8, 4, 8, 64, 1});  // 16 extra quarters then timeout
    push_normal(4);
    exp_q.push_back('{20, 12, 8, 4, 8, 4, 0});   // one extra quarter
    exp_q.push_back('{80, 72, 8, 4, 8, 64, 1});  // timeout again, nWAIT kept low

    RESET = 1'b0;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("mhz12_t%0d", t), int'(MHZ12), int'(mhz_pat[i]));
    end

    wait_until(37);
    SPEED = 2'd2;
    wait_until(60);
    SPEED = 2'd0;

    wait_until(136);
    nWAIT = 1'b0;
    wait_until(206);
    nWAIT = 1'b1;
    wait_until(207);
    CLR_TO = 1'b1;
    wait_until(208);
    check("wait_to_set_beats_clr", int'(WAIT_TO), 1);
    check("wait_active_cleared", int'(WAIT_ACTIVE), 0);
    wait_until(209);
    check("wait_to_cleared", int'(WAIT_TO), 0);
    CLR_TO = 1'b0;

    wait_until(237);
    nWAIT = 1'b0;
    wait_until(238);
    nWAIT = 1'b1;
    wait_until(244);
    check("short_wait_cyc_end", int'(CYC_END), 1);
    check("short_wait_no_timeout", int'(WAIT_TO), 0);

    wait_until(252);
    nWAIT = 1'b0;
    wait_until(345);
    check("pre_rst_wait_active", int'(WAIT_ACTIVE), 1);
    check("pre_rst_wait_to", int'(WAIT_TO), 1);
    check("pre_rst_nE", int'(nE), 0);
    check("pre_rst_nQ", int'(nQ), 1);
    RESET = 1'b1;
    nWAIT = 1'b1;
    tick();
    check("mid_rst_nE", int'(nE), 1);
    check("mid_rst_nQ", int'(nQ), 1);
    check("mid_rst_wait_active", int'(WAIT_ACTIVE), 0);
    check("mid_rst_wait_to", int'(WAIT_TO), 0);
    check("mid_rst_cyc_end", int'(CYC_END), 0);
    RESET = 1'b0;
    t = 0;
    push_normal(4);
    push_normal(4);

    wait_until(40);
    check("queue_drained", exp_q.size(), 0);
    check("cycles_seen", m_cyc, 11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
